// File: rtl/cnn_dma_wr_slave.sv
// AXI write-burst responder for the CNN accelerator: steers data beats into the image,
// weight or bias buffers and turns DMA mapping writes into load-done flags and a start pulse.
module cnn_dma_wr_slave #(
  parameter int unsigned IMG_DEPTH = 3072,
  parameter int unsigned W_DEPTH   = 1024,
  parameter int unsigned B_DEPTH   = 64,
  parameter int unsigned IDX_W     = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      AWADDR,
  input  logic [3:0]       AWLEN,
  input  logic             AWVALID,
  output logic             AWREADY,
  input  logic [31:0]      WDATA,
  input  logic             WLAST,
  input  logic             WVALID,
  output logic             WREADY,
  output logic [1:0]       BRESP,
  output logic             BVALID,
  input  logic             BREADY,
  input  logic             buf_ready,
  output logic [2:0]       buf_we,
  output logic [IDX_W-1:0] buf_idx,
  output logic [31:0]      buf_wdata,
  output logic             img_done,
  output logic             w_done,
  output logic             b_done,
  output logic             cnn_start,
  input  logic             done_clr
);

  // One extra offset bit so a burst running past the end of a region never wraps back in range
  localparam int unsigned OW = IDX_W + 1;
  localparam logic [OW-1:0] IMG_D = OW'(IMG_DEPTH);
  localparam logic [OW-1:0] W_D   = OW'(W_DEPTH);
  localparam logic [OW-1:0] B_D   = OW'(B_DEPTH);
  localparam logic [OW-1:0] OFF_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;
  typedef enum logic [2:0] {R_NONE, R_IMG, R_W, R_B, R_MAP} region_t;

  state_t        state, state_n;
  region_t       region, region_n;
  logic [OW-1:0] offset, offset_n;
  logic [3:0]    cnt, cnt_n;
  logic          err, err_n;
  logic          overrun, overrun_n;
  logic          map_first, map_first_n;
  logic [15:0]   addr_lo, addr_lo_n;

  logic             awready_q, awready_n;
  logic             bvalid_q, bvalid_n;
  logic [1:0]       bresp_q, bresp_n;
  logic [2:0]       we_q, we_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic [31:0]      wdata_q, wdata_n;
  logic             img_q, img_n, w_q, w_n, b_q, b_n;
  logic             all_d, start_q, start_n;

  logic          wready_c;
  logic          hs_c;
  logic          extra_c;
  logic [OW-1:0] depth_c;
  logic          set_img, set_w, set_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      region    <= R_NONE;
      offset    <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      overrun   <= 1'b0;
      map_first <= 1'b0;
      addr_lo   <= '0;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      we_q      <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      img_q     <= 1'b0;
      w_q       <= 1'b0;
      b_q       <= 1'b0;
      all_d     <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state     <= state_n;
      region    <= region_n;
      offset    <= offset_n;
      cnt       <= cnt_n;
      err       <= err_n;
      overrun   <= overrun_n;
      map_first <= map_first_n;
      addr_lo   <= addr_lo_n;
      awready_q <= awready_n;
      bvalid_q  <= bvalid_n;
      bresp_q   <= bresp_n;
      we_q      <= we_n;
      idx_q     <= idx_n;
      wdata_q   <= wdata_n;
      img_q     <= img_n;
      w_q       <= w_n;
      b_q       <= b_n;
      all_d     <= img_q & w_q & b_q;
      start_q   <= start_n;
    end
  end

  always_comb begin
    state_n     = state;
    region_n    = region;
    offset_n    = offset;
    cnt_n       = cnt;
    err_n       = err;
    overrun_n   = overrun;
    map_first_n = map_first;
    addr_lo_n   = addr_lo;
    we_n        = '0;
    idx_n       = idx_q;
    wdata_n     = wdata_q;
    set_img     = 1'b0;
    set_w       = 1'b0;
    set_b       = 1'b0;

    // Map and unmapped regions never back-pressure; real buffers follow buf_ready
    wready_c = 1'b0;
    if (state == S_DATA)
      wready_c = (region == R_MAP || region == R_NONE) ? 1'b1 : buf_ready;
    hs_c    = WVALID & wready_c;
    extra_c = overrun | ((cnt == 4'd0) & ~WLAST);

    case (region)
      R_IMG:   depth_c = IMG_D;
      R_W:     depth_c = W_D;
      R_B:     depth_c = B_D;
      default: depth_c = '0;
    endcase

    case (state)
      S_IDLE: begin
        if (AWVALID && awready_q) begin
          case (AWADDR[31:16])
            16'hD555: region_n = R_IMG;
            16'hD333: region_n = R_W;
            16'hD444: region_n = R_B;
            16'hDCCC: region_n = R_MAP;
            default:  region_n = R_NONE;
          endcase
          err_n       = (AWADDR[31:16] != 16'hD555) && (AWADDR[31:16] != 16'hD333) &&
                        (AWADDR[31:16] != 16'hD444) && (AWADDR[31:16] != 16'hDCCC);
          offset_n    = {1'b0, AWADDR[IDX_W+1:2]};
          cnt_n       = AWLEN;
          overrun_n   = 1'b0;
          map_first_n = 1'b1;
          addr_lo_n   = AWADDR[15:0];
          state_n     = S_DATA;
        end
      end
      S_DATA: begin
        if (hs_c) begin
          offset_n = (offset == OFF_MAX) ? offset : OW'(offset + OW'(1));
          cnt_n    = (cnt == 4'd0) ? 4'd0 : 4'(cnt - 4'd1);
          if (extra_c) begin
            err_n     = 1'b1;
            overrun_n = 1'b1;
          end else begin
            case (region)
              R_IMG, R_W, R_B: begin
                if (offset < depth_c) begin
                  we_n    = (region == R_IMG) ? 3'b001 : (region == R_W) ? 3'b010 : 3'b100;
                  idx_n   = offset[IDX_W-1:0];
                  wdata_n = WDATA;
                end else begin
                  err_n = 1'b1;
                end
              end
              R_MAP: begin
                map_first_n = 1'b0;
                if (map_first && WDATA == 32'd1 && addr_lo == 16'hFFFF)      set_img = 1'b1;
                else if (map_first && WDATA == 32'd1 && addr_lo == 16'h0000) set_w   = 1'b1;
                else if (map_first && WDATA == 32'd1 && addr_lo == 16'h1111) set_b   = 1'b1;
                else err_n = 1'b1;
              end
              default: err_n = 1'b1;
            endcase
          end
          if (WLAST) begin
            state_n = S_RESP;
            if (cnt != 4'd0) err_n = 1'b1;
          end
        end
      end
      S_RESP: begin
        if (BREADY) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    awready_n = (state_n == S_IDLE);
    bvalid_n  = (state_n == S_RESP);
    bresp_n   = (state_n == S_RESP) ? {err_n, 1'b0} : 2'b00;

    // Sticky flags: a set in the same cycle as done_clr wins
    img_n   = set_img | (img_q & ~done_clr);
    w_n     = set_w   | (w_q   & ~done_clr);
    b_n     = set_b   | (b_q   & ~done_clr);
    start_n = img_q & w_q & b_q & ~all_d;
  end

  assign AWREADY   = awready_q;
  assign WREADY    = wready_c;
  assign BVALID    = bvalid_q;
  assign BRESP     = bresp_q;
  assign buf_we    = we_q;
  assign buf_idx   = idx_q;
  assign buf_wdata = wdata_q;
  assign img_done  = img_q;
  assign w_done    = w_q;
  assign b_done    = b_q;
  assign cnn_start = start_q;

endmodule

// File: doc/cnn_dma_wr_slave.md
Name: cnn_dma_wr_slave

Overview:
Write-side responder that sits between the AXI interconnect and the CNN accelerator's local buffers. It is the receiving end of the DMA engine's write bursts. It accepts AXI write bursts and decodes the destination region: image 0xD555_xxxx, weight 0xD333_xxxx, bias 0xD444_xxxx. Each data beat goes to the matching buffer write port. It also recognises the DMA's mapping/completion writes (0xDCCC_xxxx) and raises per-region load-done flags and a one-cycle CNN start pulse.

Parameters:
IMG_DEPTH  3072  image buffer depth in words
W_DEPTH  1024  weight buffer depth in words
B_DEPTH  64  bias buffer depth in words
IDX_W  12  buffer index width; must satisfy 2^IDX_W >= max depth

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
AWADDR  in  32  burst start byte address
AWLEN  in  4  beats-1
AWVALID  in  1  address valid
AWREADY  out  1  address accepted
WDATA  in  32  write data
WLAST  in  1  last beat
WVALID  in  1  data valid
WREADY  out  1  data accepted
BRESP  out  2  00 OKAY, 10 SLVERR
BVALID  out  1  response valid
BREADY  in  1  response accepted
buf_ready  in  1  buffers can take a write this cycle
buf_we  out  3  one-hot write enable: [0] image, [1] weight, [2] bias
buf_idx  out  IDX_W  word index in the selected buffer
buf_wdata  out  32  write data to the buffer
img_done  out  1  image load complete (sticky)
w_done  out  1  weight load complete (sticky)
b_done  out  1  bias load complete (sticky)
cnn_start  out  1  one-cycle pulse when all three done flags are set
done_clr  in  1  clears all done flags

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. On reset every output is 0, the FSM returns to IDLE and any in-flight burst is abandoned with no further buf_we.
- FSM states: IDLE, DATA, RESP.
- IDLE:
  - AWREADY=1.
  - On AWVALID, latch region, offset = AWADDR[IDX_W+1:2], beat counter = AWLEN, err=0; go to DATA.
- Region decode from AWADDR[31:16]:
  - D555 image, D333 weight, D444 bias, DCCC map.
  - Any other value is region NONE, which sets err=1.
- DATA:
  - WREADY = buf_ready when region is image/weight/bias; WREADY = 1 when region is map or NONE.
  - Beat handshake is WVALID & WREADY.
  - Per handshake: offset+1 (word granularity, equal to byte address +4), counter-1.
  - On WLAST handshake go to RESP. If the counter is not 0 at WLAST, set err.
  - If the counter reaches 0 without WLAST, further beats are accepted, dropped, and set err.
- Buffer write:
  - Registered, issued one cycle after the handshake: buf_we one-hot, buf_idx = offset at handshake, buf_wdata = WDATA.
  - buf_we is 0 in all other cycles.
- Range check: offset >= depth of the region means the beat is accepted and dropped (no buf_we) and err is set. Offset does not wrap.
- Map writes are decoded on the full latched address:
  - DCCCFFFF with WDATA==1 sets img_done.
  - DCCC0000 with WDATA==1 sets w_done.
  - DCCC1111 with WDATA==1 sets b_done.
  - Any other DCCC address, or WDATA!=1, sets err.
  - Only the first beat of a map burst is decoded; later beats set err.
- RESP:
  - BVALID=1, BRESP = err ? 10 : 00.
  - Hold until BREADY, then return to IDLE. AWREADY=0 while in RESP.
- Done flags:
  - Flags are sticky and cleared by done_clr.
  - If a set and done_clr occur in the same cycle, the set wins.
- cnn_start:
  - Pulses exactly one cycle, on the cycle after the last of the three flags becomes set (rising edge of img_done&w_done&b_done).
  - Does not repeat until the flags are cleared and all three are set again.
- Back-to-back bursts: the earliest new AW acceptance is the cycle after the BREADY handshake.

Test Plan:
1. Reset held 3 cycles, then released -> every output 0, AWREADY=1 the cycle after release.
2. AW 0xD5550000, AWLEN=3, data A0..A3 with buf_ready=1 -> buf_we=001 with idx 0,1,2,3 each one cycle after its beat; BRESP=00.
3. Weight burst at 0xD3330010 (AWLEN=1) with buf_ready toggling 0/1 -> WREADY follows buf_ready; writes to idx 4,5 only; no beat lost or duplicated.
4. Map writes:
   - 0xDCCCFFFF, 0xDCCC0000, 0xDCCC1111, each WDATA=1 -> flags set in order; cnn_start pulses once, one cycle after b_done rises.
   - done_clr=1 -> all flags 0.
5. Bias burst at 0xD444_00FC with AWLEN=1 (offset 63, then 64) -> idx 63 written, second beat dropped, BRESP=10. AW 0x12340000 -> all beats dropped, BRESP=10.
6. Reset asserted mid-burst after beat 2 of 4 -> no buf_we after reset; FSM in IDLE; BVALID=0.
